// File: rtl/ofdm_rx_seq_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// ofdm_rx_seq_ctrl_pkg
// Shared definitions for the OFDM RX frame sequencer:
//   - seq_state_e   : sequencer states (IDLE, INIT, SEARCH, RECEIVE, DONE, TOUT)
//   - MIN_LEVEL_RST : detection threshold applied out of reset
//   - BIT_CNT_W     : width of the received-bit counter
//   - UNDERRUN_MAX  : saturation value of the optional underrun counter
//   - is_feeding()  : true in the states that pace samples into the RX chain
// ---------------------------------------------------------------------------
package ofdm_rx_seq_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_INIT    = 3'd1,
        ST_SEARCH  = 3'd2,
        ST_RECEIVE = 3'd3,
        ST_DONE    = 3'd4,
        ST_TOUT    = 3'd5
    } seq_state_e;

    localparam logic [15:0] MIN_LEVEL_RST = 16'd32064;
    localparam int          BIT_CNT_W     = 32;
    localparam logic [15:0] UNDERRUN_MAX  = 16'hFFFF;

    function automatic logic is_feeding(input seq_state_e st);
        return (st == ST_SEARCH) || (st == ST_RECEIVE);
    endfunction

endpackage

// File: rtl/ofdm_rx_strobe_gen.sv
// ---------------------------------------------------------------------------
// ofdm_rx_strobe_gen
// Divide-by-DIV_G sample strobe. The counter runs 0..DIV_G-1 while enabled
// and holds otherwise; a synchronous clear returns it to 0.
// Ports:
//   clk    in  : system clock
//   rst    in  : asynchronous reset, active-high
//   clr    in  : synchronous clear of the counter
//   en     in  : count enable
//   strobe out : combinational, high while enabled and count == DIV_G-1
// ---------------------------------------------------------------------------
module ofdm_rx_strobe_gen #(
    parameter int DIV_G = 25
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic strobe
);

    localparam int             CW   = (DIV_G > 2) ? $clog2(DIV_G) : 1;
    localparam logic [CW-1:0]  LAST = CW'(DIV_G - 1);
    localparam logic [CW-1:0]  ONE  = {{(CW-1){1'b0}}, 1'b1};

    logic [CW-1:0] cnt_r;

    // Free-running divider, wraps after LAST.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= '0;
        end else if (clr) begin
            cnt_r <= '0;
        end else if (en) begin
            if (cnt_r == LAST) begin
                cnt_r <= '0;
            end else begin
                cnt_r <= cnt_r + ONE;
            end
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign strobe = en & (cnt_r == LAST);

endmodule

// File: rtl/ofdm_rx_seq_ctrl.sv
// ---------------------------------------------------------------------------
// ofdm_rx_seq_ctrl
// Sequences one OFDM RX frame: pulses sys_init to the RX chain, paces ADC
// samples into it at one per STROBE_DIV_G clocks, waits for symbol sync,
// then counts 2-bit outputs until RAW_BITS_G*FRAME_SYMS_G bits arrived.
// A watchdog aborts the frame after TIMEOUT_G cycles without progress.
// Optional feature: define OFDM_RX_SEQ_CTRL_STATS_EN to add underrun_cnt,
// a saturating count of sample strobes that found no upstream sample.
// Ports:
//   sys_clk, sys_rst          clock, async active-high reset
//   start, abort              1-cycle frame request / return to IDLE
//   cfg_we, min_level_cfg     threshold shadow write
//   src_valid, src_i, src_q   upstream samples; src_ready pops (comb)
//   rx_data_i/q, rx_data_valid  registered sample to the RX chain
//   sys_init, min_level       RX chain init pulse and active threshold
//   rx_symbols_start          symbol-sync indication from RX chain
//   rx_rcv_data_valid         2-bit output strobe from RX chain
//   busy, done, timeout       status (done 1-cycle, timeout sticky)
//   bit_cnt                   bits received in the current frame
//   underrun_cnt              (STATS_EN only) skipped strobes
// ---------------------------------------------------------------------------
module ofdm_rx_seq_ctrl
    import ofdm_rx_seq_ctrl_pkg::*;
#(
    parameter int SAMPLE_W_G   = 12,
    parameter int STROBE_DIV_G = 25,
    parameter int RAW_BITS_G   = 96,
    parameter int FRAME_SYMS_G = 12,
    parameter int TIMEOUT_G    = 500000
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic                  cfg_we,
    input  logic [15:0]           min_level_cfg,
    input  logic                  src_valid,
    input  logic [SAMPLE_W_G-1:0] src_i,
    input  logic [SAMPLE_W_G-1:0] src_q,
    output logic                  src_ready,
    output logic [SAMPLE_W_G-1:0] rx_data_i,
    output logic [SAMPLE_W_G-1:0] rx_data_q,
    output logic                  rx_data_valid,
    output logic                  sys_init,
    output logic [15:0]           min_level,
    input  logic                  rx_symbols_start,
    input  logic                  rx_rcv_data_valid,
    output logic                  busy,
    output logic                  done,
    output logic                  timeout,
`ifdef OFDM_RX_SEQ_CTRL_STATS_EN
    output logic [15:0]           underrun_cnt,
`endif
    output logic [BIT_CNT_W-1:0]  bit_cnt
);

    localparam logic [BIT_CNT_W-1:0] TARGET   = BIT_CNT_W'(RAW_BITS_G * FRAME_SYMS_G);
    localparam logic [BIT_CNT_W-1:0] BIT_STEP = 32'd2;
    localparam int                   WD_W     = (TIMEOUT_G > 2) ? $clog2(TIMEOUT_G) : 1;
    localparam logic [WD_W-1:0]      WD_LAST  = WD_W'(TIMEOUT_G - 1);
    localparam logic [WD_W-1:0]      WD_ONE   = {{(WD_W-1){1'b0}}, 1'b1};

    seq_state_e                state_r;
    seq_state_e                state_next_s;
    logic                      feeding_s;
    logic                      start_ok_s;
    logic                      strobe_s;
    logic                      pop_s;
    logic                      bits_full_s;
    logic                      wd_expired_s;
    logic [WD_W-1:0]           wd_r;
    logic [BIT_CNT_W-1:0]      bit_cnt_r;
    logic [15:0]               shadow_r;
    logic [15:0]               min_level_r;
    logic [SAMPLE_W_G-1:0]     rx_data_i_r;
    logic [SAMPLE_W_G-1:0]     rx_data_q_r;
    logic                      rx_data_valid_r;
    logic                      sys_init_r;
    logic                      busy_r;
    logic                      done_r;
    logic                      timeout_r;

    assign feeding_s   = is_feeding(state_r);
    assign start_ok_s  = (state_r == ST_IDLE) & start & ~abort;
    // abort suppresses the pop so no sample is lost mid-abort
    assign pop_s       = strobe_s & feeding_s & src_valid & ~abort;
    assign bits_full_s = (bit_cnt_r >= TARGET);
    // a 2-bit output in the expiry cycle counts as progress, not a timeout
    assign wd_expired_s = feeding_s & ~rx_rcv_data_valid & (wd_r >= WD_LAST);

    ofdm_rx_strobe_gen #(
        .DIV_G (STROBE_DIV_G)
    ) u_strobe (
        .clk    (sys_clk),
        .rst    (sys_rst),
        .clr    (state_r == ST_INIT),
        .en     (feeding_s),
        .strobe (strobe_s)
    );

    // Next-state selection; abort overrides everything.
    always_comb begin
        state_next_s = state_r;
        if (abort) begin
            state_next_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        state_next_s = ST_INIT;
                    end else begin
                        state_next_s = ST_IDLE;
                    end
                end
                ST_INIT: begin
                    state_next_s = ST_SEARCH;
                end
                ST_SEARCH: begin
                    if (rx_symbols_start) begin
                        state_next_s = ST_RECEIVE;
                    end else if (wd_expired_s) begin
                        state_next_s = ST_TOUT;
                    end else begin
                        state_next_s = ST_SEARCH;
                    end
                end
                ST_RECEIVE: begin
                    // completion is checked first so it wins over expiry
                    if (bits_full_s) begin
                        state_next_s = ST_DONE;
                    end else if (wd_expired_s) begin
                        state_next_s = ST_TOUT;
                    end else begin
                        state_next_s = ST_RECEIVE;
                    end
                end
                ST_DONE: begin
                    state_next_s = ST_IDLE;
                end
                ST_TOUT: begin
                    state_next_s = ST_IDLE;
                end
                default: begin
                    state_next_s = ST_IDLE;
                end
            endcase
        end
    end

    // State register and state-derived status outputs.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_r    <= ST_IDLE;
            busy_r     <= 1'b0;
            sys_init_r <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            state_r    <= state_next_s;
            busy_r     <= (state_next_s != ST_IDLE);
            sys_init_r <= (state_next_s == ST_INIT);
            done_r     <= (state_next_s == ST_DONE);
        end
    end

    // Sticky timeout flag, cleared only by an accepted start.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            timeout_r <= 1'b0;
        end else if (start_ok_s) begin
            timeout_r <= 1'b0;
        end else if (state_next_s == ST_TOUT) begin
            timeout_r <= 1'b1;
        end else begin
            timeout_r <= timeout_r;
        end
    end

    // Watchdog: zero at SEARCH entry, reset on each 2-bit output, saturates.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            wd_r <= '0;
        end else if (state_r == ST_INIT) begin
            wd_r <= '0;
        end else if (feeding_s) begin
            if (rx_rcv_data_valid) begin
                wd_r <= '0;
            end else if (wd_r < WD_LAST) begin
                wd_r <= wd_r + WD_ONE;
            end else begin
                wd_r <= wd_r;
            end
        end else begin
            wd_r <= wd_r;
        end
    end

    // Received-bit counter; stops at the frame target, holds after the frame.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            bit_cnt_r <= '0;
        end else if (start_ok_s) begin
            bit_cnt_r <= '0;
        end else if ((state_r == ST_RECEIVE) && rx_rcv_data_valid && !bits_full_s) begin
            bit_cnt_r <= bit_cnt_r + BIT_STEP;
        end else begin
            bit_cnt_r <= bit_cnt_r;
        end
    end

    // Threshold shadow and active value; active only changes while idle.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            shadow_r    <= MIN_LEVEL_RST;
            min_level_r <= MIN_LEVEL_RST;
        end else begin
            if (cfg_we) begin
                shadow_r <= min_level_cfg;
            end else begin
                shadow_r <= shadow_r;
            end
            if (state_r == ST_IDLE) begin
                if (cfg_we) begin
                    min_level_r <= min_level_cfg;
                end else if (start_ok_s) begin
                    min_level_r <= shadow_r;
                end else begin
                    min_level_r <= min_level_r;
                end
            end else begin
                min_level_r <= min_level_r;
            end
        end
    end

    // Sample register towards the RX chain, one cycle after the pop.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            rx_data_i_r     <= '0;
            rx_data_q_r     <= '0;
            rx_data_valid_r <= 1'b0;
        end else begin
            rx_data_valid_r <= pop_s;
            if (pop_s) begin
                rx_data_i_r <= src_i;
                rx_data_q_r <= src_q;
            end else begin
                rx_data_i_r <= rx_data_i_r;
                rx_data_q_r <= rx_data_q_r;
            end
        end
    end

`ifdef OFDM_RX_SEQ_CTRL_STATS_EN
    logic [15:0] underrun_r;
    logic        skip_s;

    assign skip_s = strobe_s & feeding_s & ~src_valid & ~abort;

    // Saturating count of strobes that found no sample.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            underrun_r <= '0;
        end else if (start_ok_s) begin
            underrun_r <= '0;
        end else if (skip_s && (underrun_r != UNDERRUN_MAX)) begin
            underrun_r <= underrun_r + 16'd1;
        end else begin
            underrun_r <= underrun_r;
        end
    end

    assign underrun_cnt = underrun_r;
`endif

    assign src_ready     = pop_s;
    assign rx_data_i     = rx_data_i_r;
    assign rx_data_q     = rx_data_q_r;
    assign rx_data_valid = rx_data_valid_r;
    assign sys_init      = sys_init_r;
    assign min_level     = min_level_r;
    assign busy          = busy_r;
    assign done          = done_r;
    assign timeout       = timeout_r;
    assign bit_cnt       = bit_cnt_r;

endmodule
